// File: rtl/pixel_clip_fifo_if.sv
// Pixel bus between drawing engine, clip FIFO and VGA adapter.
// master = engine/adapter side (bench), slave = pixel_clip_fifo.
interface pixel_clip_fifo_if;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic       out_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output in_x, in_y, in_colour, in_plot, out_ready,
    input  vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  in_x, in_y, in_colour, in_plot, out_ready,
    output vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/pixel_clip_fifo.sv
// Clips engine plot strobes to the screen, buffers on-screen pixels in a
// small FIFO and replays them to the VGA adapter one per ready cycle.
// Saturating plotted/clipped/dropped counters are kept for debug.
module pixel_clip_fifo #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  pixel_clip_fifo_if.slave   bus,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic [15:0]        count_plotted,
  output logic [15:0]        count_clipped,
  output logic [15:0]        count_dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [8:0]  X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM    = 8'(SCREEN_H);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_t;

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  pix_t          head;
  logic          in_bounds, push_req, push, pop, clip, drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);
  assign head  = mem[rd_ptr];

  // Unsigned bounds compare; clear discards the same-edge strobe entirely.
  assign in_bounds = ({1'b0, bus.in_x} < X_LIM) && ({1'b0, bus.in_y} < Y_LIM);
  assign pop       = !clear && !empty && bus.out_ready;
  assign push_req  = !clear && bus.in_plot && in_bounds;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign clip      = !clear && bus.in_plot && !in_bounds;

  // FIFO storage; contents need no reset, occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_t'{bus.in_x, bus.in_y, bus.in_colour};
  end

  // Pointers wrap modulo DEPTH; occupancy tracks 0..DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Registered adapter side: data holds between pops, strobe lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
    end else begin
      bus.vga_plot <= pop;
      if (pop) begin
        bus.vga_x      <= head.x;
        bus.vga_y      <= head.y;
        bus.vga_colour <= head.colour;
      end
    end
  end

  // Saturating event counters and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_plotted <= '0;
      count_clipped <= '0;
      count_dropped <= '0;
      overflow      <= 1'b0;
    end else if (clear) begin
      count_plotted <= '0;
      count_clipped <= '0;
      count_dropped <= '0;
      overflow      <= 1'b0;
    end else begin
      if (pop)  count_plotted <= sat_inc(count_plotted);
      if (clip) count_clipped <= sat_inc(count_clipped);
      if (drop) begin
        count_dropped <= sat_inc(count_dropped);
        overflow      <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Randomised + directed bench for pixel_clip_fifo. A queue-level model
// predicts emitted pixels into a scoreboard; a negedge monitor compares.
module tb_pixel_clip_fifo;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic empty, full, overflow;
  logic [15:0] count_plotted, count_clipped, count_dropped;

  pixel_clip_fifo_if bus ();

  pixel_clip_fifo #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave),
    .empty(empty), .full(full), .overflow(overflow),
    .count_plotted(count_plotted), .count_clipped(count_clipped),
    .count_dropped(count_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (queue of pending pixels, expected outputs).
  logic [17:0] mq[$];
  logic [17:0] exp_q[$];
  logic        m_plot = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_plotted = 0, m_clipped = 0, m_dropped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Model: what a clipping, bounded FIFO should do on each edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); exp_q.delete();
        m_plot = 1'b0; m_ovf = 1'b0;
        m_plotted = 0; m_clipped = 0; m_dropped = 0;
      end else if (clear) begin
        mq.delete();
        m_plot = 1'b0; m_ovf = 1'b0;
        m_plotted = 0; m_clipped = 0; m_dropped = 0;
      end else begin
        int  sz;
        logic popped;
        sz = mq.size();
        popped = (sz > 0) && bus.out_ready;
        m_plot = popped;
        if (popped) begin
          exp_q.push_back(mq.pop_front());
          m_plotted = sat(m_plotted);
        end
        if (bus.in_plot) begin
          if (int'(bus.in_x) >= 160 || int'(bus.in_y) >= 120) m_clipped = sat(m_clipped);
          else if (sz < DEPTH || popped) mq.push_back({bus.in_x, bus.in_y, bus.in_colour});
          else begin
            m_dropped = sat(m_dropped);
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: every cycle, compare strobe/status; on a strobe, pop the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      chk("vga_plot", bus.vga_plot, m_plot);
      if (bus.vga_plot) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pixel: got %0h expected none at %0t",
                   {bus.vga_x, bus.vga_y, bus.vga_colour}, $time);
        end else begin
          chk("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, exp_q.pop_front());
        end
      end
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("count_plotted", count_plotted, m_plotted);
      chk("count_clipped", count_clipped, m_clipped);
      chk("count_dropped", count_dropped, m_dropped);
      if (!rst_n) chk("reset_vga", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    end
  end

  task automatic drive(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input logic p, input logic r);
    @(negedge clk);
    bus.in_x = x; bus.in_y = y; bus.in_colour = c;
    bus.in_plot = p; bus.out_ready = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(8'd0, 7'd0, 3'd0, 1'b0, r);
  endtask

  initial begin
    bus.in_x = '0; bus.in_y = '0; bus.in_colour = '0;
    bus.in_plot = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: single pixel, emitted two edges later
    drive(8'd80, 7'd60, 3'd7, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("t1_plotted", count_plotted, 1);
    chk("t1_empty", empty, 1);

    // 2: boundary clipping
    drive(8'd159, 7'd119, 3'd1, 1'b1, 1'b1);
    drive(8'd160, 7'd10,  3'd2, 1'b1, 1'b1);
    drive(8'd10,  7'd120, 3'd3, 1'b1, 1'b1);
    drive(8'd255, 7'd127, 3'd4, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("t2_clipped", count_clipped, 3);
    chk("t2_plotted", count_plotted, 2);

    // 3: overflow with adapter stalled, then drain in order
    for (int i = 0; i < 10; i++) drive(8'(i + 20), 7'(i + 5), 3'(i), 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("t3_full", full, 1);
    chk("t3_dropped", count_dropped, 2);
    chk("t3_overflow", overflow, 1);
    idle(10, 1'b1);
    chk("t3_plotted", count_plotted, 10);

    // 4: full FIFO, push+pop every cycle
    for (int i = 0; i < 8; i++) drive(8'(i + 40), 7'(i), 3'(i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'(i + 100), 7'(i + 50), 3'(i), 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("t4_dropped", count_dropped, 2);
    idle(10, 1'b1);

    // 5: clear with a same-edge strobe
    for (int i = 0; i < 4; i++) drive(8'(i + 1), 7'(i + 1), 3'(i), 1'b1, 1'b0);
    drive(8'd5, 7'd5, 3'd5, 1'b1, 1'b0);
    clear = 1'b1;
    drive(8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
    clear = 1'b0;
    chk("t5_empty", empty, 1);
    chk("t5_counts", {count_plotted, count_clipped}, 0);
    chk("t5_overflow", overflow, 0);
    idle(4, 1'b1);

    // 6: asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) drive(8'(i + 60), 7'(i + 60), 3'(i), 1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_plot", bus.vga_plot, 0);
    chk("t6_async_vga", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    chk("t6_async_cnt", count_plotted, 0);
    chk("t6_async_empty", empty, 1);
    bus.in_plot = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(5, 1'b1);

    // Random traffic: mixed legal/clipped pixels, bursty ready, rare clears.
    for (int i = 0; i < 1500; i++) begin
      logic p, r;
      p = ($urandom_range(99) < 70);
      r = ($urandom_range(99) < 60);
      clear = ($urandom_range(199) == 0);
      drive(8'($urandom_range(175)), 7'($urandom_range(127)), 3'($urandom),
            p, r);
    end
    clear = 1'b0;
    idle(DEPTH + 4, 1'b1);
    chk("drain_scoreboard", exp_q.size(), 0);
    chk("drain_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
